// File: rtl/regfile_wb_scheduler.sv
// Regfile writeback scheduler: round-robin shares one write port between ALU and LSU,
// and tracks outstanding loads in a per-register scoreboard that drives the decode hazard stall.
module regfile_wb_scheduler #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [AW-1:0]   alu_rd_i,
    input  logic [DW-1:0]   alu_data_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [AW-1:0]   lsu_rd_i,
    input  logic [DW-1:0]   lsu_data_i,
    input  logic            iss_load_i,
    input  logic [AW-1:0]   iss_rd_i,
    output logic            iss_ready_o,
    input  logic [AW-1:0]   rs1_id_i,
    input  logic [AW-1:0]   rs2_id_i,
    output logic            hazard_o,
    output logic            w_en_o,
    output logic [AW-1:0]   rd_id_o,
    output logic [DW-1:0]   rd_write_data_o,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            last_alu_q, last_alu_d;
    logic            w_en_q, w_en_d;
    logic [AW-1:0]   rd_id_q, rd_id_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic alu_elig, lsu_elig, grant_alu, grant_lsu, iss_set;
    logic haz1, haz2;

    // An ALU write to a register with a load still outstanding would be overwritten
    // out of order by the load, so the ALU waits until the load lands.
    assign alu_elig  = alu_valid_i && !(busy_q[alu_rd_i] && alu_rd_i != '0);
    assign lsu_elig  = lsu_valid_i;
    assign grant_alu = alu_elig && (!lsu_elig || !last_alu_q);
    assign grant_lsu = lsu_elig && (!alu_elig ||  last_alu_q);

    assign alu_ready_o = grant_alu;
    assign lsu_ready_o = grant_lsu;

    assign iss_ready_o = !busy_q[iss_rd_i] || iss_rd_i == '0;
    assign iss_set     = iss_load_i && iss_ready_o && iss_rd_i != '0;

    assign haz1 = rs1_id_i != '0 && (busy_q[rs1_id_i] || (w_en_q && rd_id_q == rs1_id_i));
    assign haz2 = rs2_id_i != '0 && (busy_q[rs2_id_i] || (w_en_q && rd_id_q == rs2_id_i));
    assign hazard_o = haz1 || haz2;

    always_comb begin
        busy_d = busy_q;
        if (grant_lsu) busy_d[lsu_rd_i] = 1'b0;
        // Set after clear so a same-cycle issue to the landing register stays pending.
        if (iss_set)   busy_d[iss_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        last_alu_d = last_alu_q;
        w_en_d     = 1'b0;
        rd_id_d    = rd_id_q;
        wdata_d    = wdata_q;
        if (grant_alu) begin
            last_alu_d = 1'b1;
            w_en_d     = alu_rd_i != '0;
            rd_id_d    = alu_rd_i;
            wdata_d    = alu_data_i;
        end else if (grant_lsu) begin
            last_alu_d = 1'b0;
            w_en_d     = lsu_rd_i != '0;
            rd_id_d    = lsu_rd_i;
            wdata_d    = lsu_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            last_alu_q <= 1'b1;
            w_en_q     <= 1'b0;
            rd_id_q    <= '0;
            wdata_q    <= '0;
        end else begin
            busy_q     <= busy_d;
            last_alu_q <= last_alu_d;
            w_en_q     <= w_en_d;
            rd_id_q    <= rd_id_d;
            wdata_q    <= wdata_d;
        end
    end

    assign w_en_o          = w_en_q;
    assign rd_id_o         = rd_id_q;
    assign rd_write_data_o = wdata_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: a behavioural model predicts grants, hazards and
// the scoreboard each cycle; predicted writes are queued and checked by an independent monitor.
module tb_regfile_wb_scheduler;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid_i, lsu_valid_i, iss_load_i;
    logic [AW-1:0]   alu_rd_i, lsu_rd_i, iss_rd_i, rs1_id_i, rs2_id_i;
    logic [DW-1:0]   alu_data_i, lsu_data_i;
    logic            alu_ready_o, lsu_ready_o, iss_ready_o, hazard_o, w_en_o;
    logic [AW-1:0]   rd_id_o;
    logic [DW-1:0]   rd_write_data_o;
    logic [NREG-1:0] busy_o;

    regfile_wb_scheduler #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .iss_load_i(iss_load_i), .iss_rd_i(iss_rd_i), .iss_ready_o(iss_ready_o),
        .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i), .hazard_o(hazard_o),
        .w_en_o(w_en_o), .rd_id_o(rd_id_o), .rd_write_data_o(rd_write_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    // Reference model state
    bit          mb[NREG];
    string       last_winner;
    bit          m_wen;
    int          m_rd;
    bit          last_ga, last_gl;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        foreach (mb[i]) mb[i] = 0;
        last_winner = "alu";
        m_wen = 0;
        m_rd  = 0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        alu_valid_i = 0; alu_rd_i = '0; alu_data_i = '0;
        lsu_valid_i = 0; lsu_rd_i = '0; lsu_data_i = '0;
        iss_load_i  = 0; iss_rd_i = '0; rs1_id_i = '0; rs2_id_i = '0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance the model.
    task automatic step(input bit av, input int ard, input logic [DW-1:0] ad,
                        input bit lv, input int lrd, input logic [DW-1:0] ld,
                        input bit iv, input int ird, input int r1, input int r2);
        bit ea, el, ga, gl, ir, hz;
        logic [NREG-1:0] bexp;
        wr_t w;
        @(negedge clk);
        alu_valid_i = av; alu_rd_i = AW'(ard); alu_data_i = ad;
        lsu_valid_i = lv; lsu_rd_i = AW'(lrd); lsu_data_i = ld;
        iss_load_i  = iv; iss_rd_i = AW'(ird);
        rs1_id_i = AW'(r1); rs2_id_i = AW'(r2);
        #1;
        ea = av && !(ard != 0 && mb[ard]);
        el = lv;
        ga = 0; gl = 0;
        if (ea && el) begin
            if (last_winner == "alu") gl = 1; else ga = 1;
        end else begin
            ga = ea; gl = el;
        end
        ir = (ird == 0) || !mb[ird];
        hz = 0;
        foreach (mb[i]) bexp[i] = mb[i];
        if (r1 != 0 && (mb[r1] || (m_wen && m_rd == r1))) hz = 1;
        if (r2 != 0 && (mb[r2] || (m_wen && m_rd == r2))) hz = 1;
        chk("alu_ready", alu_ready_o, ga);
        chk("lsu_ready", lsu_ready_o, gl);
        chk("iss_ready", iss_ready_o, ir);
        chk("hazard",    hazard_o,    hz);
        chk("busy",      busy_o,      bexp);
        if (gl) mb[lrd] = 0;
        if (iv && ir && ird != 0) mb[ird] = 1;
        m_wen = 0;
        if (ga || gl) begin
            last_winner = ga ? "alu" : "lsu";
            m_rd  = ga ? ard : lrd;
            m_wen = (m_rd != 0);
            if (m_wen) begin
                w.cyc = cyc + 1; w.rd = AW'(m_rd); w.data = ga ? ad : ld;
                exp_q.push_back(w);
            end
        end
        last_ga = ga; last_gl = gl;
    endtask

    // Monitor: after every edge, any write seen must match the oldest prediction;
    // a prediction due now without a write is a missed write.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #2;
            if (rst) continue;
            if (w_en_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", w_en_o, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_rd",   rd_id_o, w.rd);
                    chk("wr_data", rd_write_data_o, w.data);
                    chk("wr_cycle", 64'(cyc), 64'(w.cyc));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                chk("missed_write", w_en_o, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit pa_v, pl_v;
        int pa_rd, pl_rd, cand[$];
        logic [DW-1:0] pa_d, pl_d;

        idle_inputs();
        rst = 1;
        model_reset();
        #1;
        chk("rst_wen",  w_en_o, 0);
        chk("rst_rd",   rd_id_o, 0);
        chk("rst_data", rd_write_data_o, 0);
        chk("rst_busy", busy_o, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // Single ALU write
        step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        chk("plan_alu_ready", alu_ready_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Round-robin tie: LSU, ALU, LSU
        step(1, 3, 32'hAAAA_0003, 1, 4, 32'h5555_0004, 0, 0, 0, 0);
        chk("rr_first_lsu", last_gl, 1);
        step(1, 3, 32'hAAAA_0003, 1, 4, 32'h5555_0004, 0, 0, 0, 0);
        chk("rr_second_alu", last_ga, 1);
        step(1, 3, 32'hAAAA_0003, 1, 4, 32'h5555_0004, 0, 0, 0, 0);
        chk("rr_third_lsu", last_gl, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load hazard on r7, ALU WAW block, LSU clears
        step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        chk("plan_hazard7", hazard_o, 1);
        chk("plan_busy7", busy_o[7], 1);
        step(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
        chk("plan_alu_blocked", alu_ready_o, 0);
        step(1, 7, 32'h77, 1, 7, 32'hD7, 0, 0, 7, 0);
        step(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
        chk("plan_haz_inflight", hazard_o, 1);
        chk("plan_busy7_clr", busy_o[7], 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        chk("plan_haz_drop", hazard_o, 0);

        // Reissue while busy is ignored; set beats clear on r9
        step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        chk("plan_iss_blocked", iss_ready_o, 0);
        step(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        chk("plan_set_wins", busy_o[9], 1);
        step(0, 0, 0, 1, 9, 32'h999, 0, 0, 0, 0);
        step(0, 0, 0, 1, 7, 32'h777, 0, 0, 0, 0);

        // Register 0
        step(0, 0, 0, 1, 0, 32'hBAD0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("plan_r0_nowrite", w_en_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("plan_r0_nohaz", hazard_o, 0);

        // Asynchronous reset mid-cycle with busy[2] pending and a write in flight
        step(1, 5, 32'hCAFE, 0, 0, 0, 1, 2, 0, 0);
        @(posedge clk);
        #3;
        chk("pre_rst_wen", w_en_o, 1);
        chk("pre_rst_busy2", busy_o[2], 1);
        rst = 1;
        idle_inputs();
        #0.5;
        chk("arst_wen",  w_en_o, 0);
        chk("arst_rd",   rd_id_o, 0);
        chk("arst_data", rd_write_data_o, 0);
        chk("arst_busy", busy_o, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        step(1, 3, 32'h3333, 1, 2, 32'h2222, 0, 0, 2, 0);
        chk("rst_tie_lsu", lsu_ready_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic on a small register window to force collisions
        pa_v = 0; pl_v = 0; pa_rd = 0; pl_rd = 0; pa_d = 0; pl_d = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!pa_v || last_ga) begin
                pa_v  = ($urandom_range(0, 99) < 60);
                pa_rd = $urandom_range(0, 7);
                pa_d  = $urandom;
            end
            if (!pl_v || last_gl) begin
                cand.delete();
                for (int r = 1; r < 8; r++) if (mb[r]) cand.push_back(r);
                pl_v  = ($urandom_range(0, 99) < 50);
                pl_rd = (cand.size() != 0 && $urandom_range(0, 9) < 8)
                        ? cand[$urandom_range(0, cand.size() - 1)] : $urandom_range(0, 7);
                pl_d  = $urandom;
            end
            last_ga = 0; last_gl = 0;
            step(pa_v, pa_rd, pa_d, pl_v, pl_rd, pl_d,
                 ($urandom_range(0, 99) < 30), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7));
            if (!pa_v) last_ga = 1;
            if (!pl_v) last_gl = 1;
        end

        for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
